branch_predictor_btb: RTL and testbench

//  Parametrised IF-stage branch predictor for the 5-stage RISC-V core: a direct-mapped BTB
//  (tag, target, type) plus per-entry 2-bit saturating counters, with a resolve port fed from MEM.

---
 rtl/branch_predictor_btb_if.sv | 38 +++
 rtl/branch_predictor_btb.sv | 137 +++++++++++++
 tb/tb_branch_predictor_btb.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_btb_if.sv
// Bundles the IF lookup, MEM resolve and statistics signals of branch_predictor_btb.
// master = pipeline side, slave = predictor side.
interface branch_predictor_btb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 8,
    parameter int CNT_WIDTH  = 32
);
    logic [DATA_WIDTH-1:0] pc;
    logic                  pred_taken;
    logic [DATA_WIDTH-1:0] pred_target;
    logic [INDEX_BITS-1:0] pred_hist;
    logic                  upd_valid;
    logic                  upd_is_jal;
    logic [DATA_WIDTH-1:0] upd_pc;
    logic                  upd_taken;
    logic [DATA_WIDTH-1:0] upd_target;
    logic                  upd_pred;
    logic [DATA_WIDTH-1:0] upd_ptarget;
    logic [INDEX_BITS-1:0] upd_hist;
    logic                  mispredict;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic [CNT_WIDTH-1:0]  stat_branch;
    logic [CNT_WIDTH-1:0]  stat_miss;

    modport master (
        output pc, upd_valid, upd_is_jal, upd_pc, upd_taken, upd_target,
               upd_pred, upd_ptarget, upd_hist,
        input  pred_taken, pred_target, pred_hist, mispredict, redirect_pc,
               stat_branch, stat_miss
    );

    modport slave (
        input  pc, upd_valid, upd_is_jal, upd_pc, upd_taken, upd_target,
               upd_pred, upd_ptarget, upd_hist,
        output pred_taken, pred_target, pred_hist, mispredict, redirect_pc,
               stat_branch, stat_miss
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit counters, MEM-stage resolve, mispredict redirect and statistics.
// Optional gshare counter indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor_btb #(
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 8,
    parameter int TAG_BITS   = 10,
    parameter int CNT_WIDTH  = 32
) (
    input logic                  clk,
    input logic                  rst,
    branch_predictor_btb_if.slave bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    logic                  valid_q   [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q     [ENTRIES];
    logic [DATA_WIDTH-1:0] target_q  [ENTRIES];
    logic                  isJal_q   [ENTRIES];
    logic [1:0]            counter_q [ENTRIES];
    logic [1:0]            counter_d;

    logic [CNT_WIDTH-1:0]  statBranch_q, statBranch_d;
    logic [CNT_WIDTH-1:0]  statMiss_q, statMiss_d;

    logic [INDEX_BITS-1:0] lkIdx, lkCntIdx, upIdx, upCntIdx;
    logic [TAG_BITS-1:0]   lkTag, upTag;
    logic                  lkHit, upHit, entryWe, mispredict;
    logic                  unusedBits;

    assign lkIdx = bp.pc[INDEX_BITS+1:2];
    assign lkTag = bp.pc[TAG_HI:TAG_LO];
    assign upIdx = bp.upd_pc[INDEX_BITS+1:2];
    assign upTag = bp.upd_pc[TAG_HI:TAG_LO];

`ifdef BP_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr_q, ghr_d;

    assign lkCntIdx     = lkIdx ^ ghr_q;
    assign upCntIdx     = upIdx ^ bp.upd_hist;
    assign bp.pred_hist = ghr_q;

    // Only conditional branches contribute to global history; LSB is the newest outcome.
    always_comb begin
        ghr_d = ghr_q;
        if (bp.upd_valid && !bp.upd_is_jal) begin
            ghr_d = {ghr_q[INDEX_BITS-2:0], bp.upd_taken};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign unusedBits = ^{bp.pc[1:0], bp.pc[DATA_WIDTH-1:TAG_HI+1],
                          bp.upd_pc[1:0], bp.upd_pc[DATA_WIDTH-1:TAG_HI+1]};
`else
    assign lkCntIdx     = lkIdx;
    assign upCntIdx     = upIdx;
    assign bp.pred_hist = '0;
    assign unusedBits   = ^{bp.pc[1:0], bp.pc[DATA_WIDTH-1:TAG_HI+1],
                            bp.upd_pc[1:0], bp.upd_pc[DATA_WIDTH-1:TAG_HI+1],
                            bp.upd_hist};
`endif

    assign lkHit          = valid_q[lkIdx] && (tag_q[lkIdx] == lkTag);
    assign bp.pred_taken  = lkHit && (isJal_q[lkIdx] || counter_q[lkCntIdx][1]);
    assign bp.pred_target = bp.pred_taken ? target_q[lkIdx] : bp.pc + DATA_WIDTH'(4);

    assign mispredict     = bp.upd_valid &&
                            ((bp.upd_pred != bp.upd_taken) ||
                             (bp.upd_taken && (bp.upd_ptarget != bp.upd_target)));
    assign bp.mispredict  = mispredict;
    assign bp.redirect_pc = !mispredict  ? '0 :
                            bp.upd_taken ? bp.upd_target : bp.upd_pc + DATA_WIDTH'(4);

    // A not-taken branch that misses leaves the table alone; everything else writes the entry.
    assign upHit   = valid_q[upIdx] && (tag_q[upIdx] == upTag);
    assign entryWe = bp.upd_valid && (upHit || bp.upd_taken);

    always_comb begin
        counter_d = counter_q[upCntIdx];
        if (!upHit) begin
            counter_d = bp.upd_taken ? 2'b10 : 2'b01;
        end else if (bp.upd_taken) begin
            if (counter_q[upCntIdx] != 2'b11) counter_d = counter_q[upCntIdx] + 2'd1;
        end else begin
            if (counter_q[upCntIdx] != 2'b00) counter_d = counter_q[upCntIdx] - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]   <= 1'b0;
                counter_q[i] <= 2'b01;
            end
        end else if (entryWe) begin
            valid_q[upIdx]      <= 1'b1;
            counter_q[upCntIdx] <= counter_d;
        end
    end

    // Tag/target payload needs no reset: it is never consulted while its valid bit is clear.
    always_ff @(posedge clk) begin
        if (entryWe) begin
            tag_q[upIdx]   <= upTag;
            isJal_q[upIdx] <= bp.upd_is_jal;
            if (bp.upd_taken) target_q[upIdx] <= bp.upd_target;
        end
    end

    always_comb begin
        statBranch_d = statBranch_q;
        statMiss_d   = statMiss_q;
        if (bp.upd_valid) statBranch_d = statBranch_q + CNT_WIDTH'(1);
        if (mispredict)   statMiss_d   = statMiss_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            statBranch_q <= '0;
            statMiss_q   <= '0;
        end else begin
            statBranch_q <= statBranch_d;
            statMiss_q   <= statMiss_d;
        end
    end

    assign bp.stat_branch = statBranch_q;
    assign bp.stat_miss   = statMiss_q;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed self-checking bench for branch_predictor_btb (default build and BP_GSHARE_EN build).
module tb_branch_predictor_btb;
    logic clk;
    logic rst;
    int   testsRun    = 0;
    int   testsFailed = 0;

    branch_predictor_btb_if #(.DATA_WIDTH(32), .INDEX_BITS(8), .CNT_WIDTH(32)) bpIf();

    branch_predictor_btb #(
        .DATA_WIDTH(32), .INDEX_BITS(8), .TAG_BITS(10), .CNT_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bp (bpIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bpIf.upd_valid   = 1'b0;
        bpIf.upd_is_jal  = 1'b0;
        bpIf.upd_pc      = '0;
        bpIf.upd_taken   = 1'b0;
        bpIf.upd_target  = '0;
        bpIf.upd_pred    = 1'b0;
        bpIf.upd_ptarget = '0;
        bpIf.upd_hist    = '0;
    endtask

    task automatic resolve(input logic isJal, input logic [31:0] pc, input logic taken,
                           input logic [31:0] target, input logic pred,
                           input logic [31:0] ptarget, input logic [7:0] hist);
        bpIf.upd_valid   = 1'b1;
        bpIf.upd_is_jal  = isJal;
        bpIf.upd_pc      = pc;
        bpIf.upd_taken   = taken;
        bpIf.upd_target  = target;
        bpIf.upd_pred    = pred;
        bpIf.upd_ptarget = ptarget;
        bpIf.upd_hist    = hist;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bpIf.pc = 32'h100;
        #2;
        testsRun++; if (bpIf.pred_taken !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_taken got %0b want 0", bpIf.pred_taken); end
        testsRun++; if (bpIf.pred_target !== 32'h104) begin testsFailed++; $display("[TB] FAIL rst_target got %h want 104", bpIf.pred_target); end
        testsRun++; if (bpIf.mispredict !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mispredict got %0b want 0", bpIf.mispredict); end
        testsRun++; if (bpIf.redirect_pc !== 32'h0) begin testsFailed++; $display("[TB] FAIL rst_redirect got %h want 0", bpIf.redirect_pc); end
        tick();
        tick();
        rst = 1'b0;
        resolve(1'b0, 32'h100, 1'b1, 32'h400, 1'b0, 32'h104, 8'h00);
        tick();
        idle();
        #1;
        testsRun++; if (bpIf.pred_taken !== 1'b1 || bpIf.pred_target !== 32'h400) begin testsFailed++; $display("[TB] FAIL pre_rst_pred got %0b/%h want 1/400", bpIf.pred_taken, bpIf.pred_target); end
        testsRun++; if (bpIf.stat_branch !== 32'd1) begin testsFailed++; $display("[TB] FAIL pre_rst_stat got %0d want 1", bpIf.stat_branch); end
        // Mid-cycle pulse: the async clear must be visible before any clock edge
        #2 rst = 1'b1;
        #1;
        testsRun++; if (bpIf.pred_taken !== 1'b0) begin testsFailed++; $display("[TB] FAIL async_rst_taken got %0b want 0", bpIf.pred_taken); end
        testsRun++; if (bpIf.pred_target !== 32'h104) begin testsFailed++; $display("[TB] FAIL async_rst_target got %h want 104", bpIf.pred_target); end
        testsRun++; if (bpIf.stat_branch !== 32'd0 || bpIf.stat_miss !== 32'd0) begin testsFailed++; $display("[TB] FAIL async_rst_stats got %0d/%0d want 0/0", bpIf.stat_branch, bpIf.stat_miss); end
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_mispredict();
        bpIf.pc = 32'h200;
        resolve(1'b0, 32'h200, 1'b1, 32'h180, 1'b0, 32'h204, 8'h00);
        #1;
        testsRun++; if (bpIf.mispredict !== 1'b1) begin testsFailed++; $display("[TB] FAIL alloc_mispredict got %0b want 1", bpIf.mispredict); end
        testsRun++; if (bpIf.redirect_pc !== 32'h180) begin testsFailed++; $display("[TB] FAIL alloc_redirect got %h want 180", bpIf.redirect_pc); end
        testsRun++; if (bpIf.pred_taken !== 1'b0) begin testsFailed++; $display("[TB] FAIL same_cycle_old got %0b want 0", bpIf.pred_taken); end
        tick();
        idle();
        #1;
        testsRun++; if (bpIf.pred_taken !== 1'b1 || bpIf.pred_target !== 32'h180) begin testsFailed++; $display("[TB] FAIL alloc_pred got %0b/%h want 1/180", bpIf.pred_taken, bpIf.pred_target); end
        testsRun++; if (bpIf.stat_branch !== 32'd1 || bpIf.stat_miss !== 32'd1) begin testsFailed++; $display("[TB] FAIL alloc_stats got %0d/%0d want 1/1", bpIf.stat_branch, bpIf.stat_miss); end
    endtask

    task automatic test_counter();
        bpIf.pc = 32'h200;
        for (int i = 0; i < 2; i++) begin
            resolve(1'b0, 32'h200, 1'b1, 32'h180, 1'b1, 32'h180, 8'h00);
            #1;
            testsRun++; if (bpIf.mispredict !== 1'b0 || bpIf.redirect_pc !== 32'h0) begin testsFailed++; $display("[TB] FAIL correct_taken_%0d got %0b/%h want 0/0", i, bpIf.mispredict, bpIf.redirect_pc); end
            tick();
        end
        resolve(1'b0, 32'h200, 1'b0, 32'h180, 1'b1, 32'h180, 8'h00);
        #1;
        testsRun++; if (bpIf.mispredict !== 1'b1 || bpIf.redirect_pc !== 32'h204) begin testsFailed++; $display("[TB] FAIL nt_redirect got %0b/%h want 1/204", bpIf.mispredict, bpIf.redirect_pc); end
        tick();
        idle();
        #1;
        testsRun++; if (bpIf.pred_taken !== 1'b1) begin testsFailed++; $display("[TB] FAIL cnt_10_taken got %0b want 1", bpIf.pred_taken); end
        resolve(1'b0, 32'h200, 1'b0, 32'h180, 1'b1, 32'h180, 8'h00);
        tick();
        idle();
        #1;
        testsRun++; if (bpIf.pred_taken !== 1'b0 || bpIf.pred_target !== 32'h204) begin testsFailed++; $display("[TB] FAIL cnt_01_pred got %0b/%h want 0/204", bpIf.pred_taken, bpIf.pred_target); end
        testsRun++; if (bpIf.stat_branch !== 32'd5 || bpIf.stat_miss !== 32'd3) begin testsFailed++; $display("[TB] FAIL cnt_stats got %0d/%0d want 5/3", bpIf.stat_branch, bpIf.stat_miss); end
    endtask

    task automatic test_target();
        bpIf.pc = 32'h280;
        resolve(1'b0, 32'h280, 1'b1, 32'h340, 1'b1, 32'h300, 8'h00);
        #1;
        testsRun++; if (bpIf.mispredict !== 1'b1 || bpIf.redirect_pc !== 32'h340) begin testsFailed++; $display("[TB] FAIL wrong_target got %0b/%h want 1/340", bpIf.mispredict, bpIf.redirect_pc); end
        tick();
        resolve(1'b0, 32'h2C0, 1'b0, 32'h2F0, 1'b0, 32'h2C4, 8'h00);
        #1;
        testsRun++; if (bpIf.mispredict !== 1'b0 || bpIf.redirect_pc !== 32'h0) begin testsFailed++; $display("[TB] FAIL correct_nt got %0b/%h want 0/0", bpIf.mispredict, bpIf.redirect_pc); end
        tick();
        idle();
        #1;
        testsRun++; if (bpIf.pred_taken !== 1'b1 || bpIf.pred_target !== 32'h340) begin testsFailed++; $display("[TB] FAIL new_target got %0b/%h want 1/340", bpIf.pred_taken, bpIf.pred_target); end
        bpIf.pc = 32'h2C0;
        #1;
        testsRun++; if (bpIf.pred_taken !== 1'b0 || bpIf.pred_target !== 32'h2C4) begin testsFailed++; $display("[TB] FAIL nt_no_alloc got %0b/%h want 0/2c4", bpIf.pred_taken, bpIf.pred_target); end
        resolve(1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 32'h504, 8'h00);
        #1;
        testsRun++; if (bpIf.mispredict !== 1'b1 || bpIf.redirect_pc !== 32'h600) begin testsFailed++; $display("[TB] FAIL jal_redirect got %0b/%h want 1/600", bpIf.mispredict, bpIf.redirect_pc); end
        tick();
        idle();
        bpIf.pc = 32'h500;
        #1;
        testsRun++; if (bpIf.pred_taken !== 1'b1 || bpIf.pred_target !== 32'h600) begin testsFailed++; $display("[TB] FAIL jal_pred got %0b/%h want 1/600", bpIf.pred_taken, bpIf.pred_target); end
    endtask

    task automatic test_aliasing();
        logic [31:0] pcA;
        logic [31:0] pcB;
        pcA = 32'h200;
        pcB = 32'h200 + (32'd4 << 8);
        resolve(1'b0, pcB, 1'b1, 32'h700, 1'b0, pcB + 32'd4, 8'h00);
        tick();
        idle();
        bpIf.pc = pcB;
        #1;
        testsRun++; if (bpIf.pred_taken !== 1'b1 || bpIf.pred_target !== 32'h700) begin testsFailed++; $display("[TB] FAIL alias_b_pred got %0b/%h want 1/700", bpIf.pred_taken, bpIf.pred_target); end
        bpIf.pc = pcA;
        #1;
        testsRun++; if (bpIf.pred_taken !== 1'b0 || bpIf.pred_target !== 32'h204) begin testsFailed++; $display("[TB] FAIL alias_a_evicted got %0b/%h want 0/204", bpIf.pred_taken, bpIf.pred_target); end
        resolve(1'b0, pcA, 1'b1, 32'h180, 1'b0, 32'h204, 8'h00);
        tick();
        idle();
        #1;
        testsRun++; if (bpIf.pred_taken !== 1'b1 || bpIf.pred_target !== 32'h180) begin testsFailed++; $display("[TB] FAIL alias_a_pred got %0b/%h want 1/180", bpIf.pred_taken, bpIf.pred_target); end
        bpIf.pc = pcB;
        #1;
        testsRun++; if (bpIf.pred_taken !== 1'b0 || bpIf.pred_target !== 32'h604) begin testsFailed++; $display("[TB] FAIL alias_b_evicted got %0b/%h want 0/604", bpIf.pred_taken, bpIf.pred_target); end
        resolve(1'b0, pcB, 1'b0, 32'h700, 1'b0, 32'h604, 8'h00);
        tick();
        idle();
        bpIf.pc = pcA;
        #1;
        testsRun++; if (bpIf.pred_taken !== 1'b1 || bpIf.pred_target !== 32'h180) begin testsFailed++; $display("[TB] FAIL alias_nt_kept got %0b/%h want 1/180", bpIf.pred_taken, bpIf.pred_target); end
    endtask

`ifdef BP_GSHARE_EN
    task automatic test_history();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        tick();
        resolve(1'b0, 32'h800, 1'b1, 32'h900, 1'b0, 32'h804, 8'h00);
        tick();
        resolve(1'b0, 32'h800, 1'b0, 32'h900, 1'b1, 32'h900, 8'hFF);
        tick();
        // Non-allocating not-taken misses flush the history back to zero
        for (int i = 0; i < 8; i++) begin
            resolve(1'b0, 32'h1010, 1'b0, 32'h0, 1'b0, 32'h1014, 8'h00);
            tick();
        end
        idle();
        bpIf.pc = 32'h800;
        #1;
        testsRun++; if (bpIf.pred_hist !== 8'h00) begin testsFailed++; $display("[TB] FAIL ghr_zero got %h want 00", bpIf.pred_hist); end
        testsRun++; if (bpIf.pred_taken !== 1'b1 || bpIf.pred_target !== 32'h900) begin testsFailed++; $display("[TB] FAIL hist00_pred got %0b/%h want 1/900", bpIf.pred_taken, bpIf.pred_target); end
        for (int i = 0; i < 8; i++) begin
            resolve(1'b0, 32'h1004, 1'b1, 32'h2000, 1'b1, 32'h2000, 8'h00);
            tick();
        end
        idle();
        #1;
        testsRun++; if (bpIf.pred_hist !== 8'hFF) begin testsFailed++; $display("[TB] FAIL ghr_ones got %h want ff", bpIf.pred_hist); end
        testsRun++; if (bpIf.pred_taken !== 1'b0 || bpIf.pred_target !== 32'h804) begin testsFailed++; $display("[TB] FAIL histff_pred got %0b/%h want 0/804", bpIf.pred_taken, bpIf.pred_target); end
    endtask
`else
    task automatic test_history();
        bpIf.pc = 32'h280;
        #1;
        testsRun++; if (bpIf.pred_hist !== 8'h00) begin testsFailed++; $display("[TB] FAIL hist_zero got %h want 00", bpIf.pred_hist); end
        resolve(1'b0, 32'h280, 1'b0, 32'h340, 1'b1, 32'h340, 8'hFF);
        tick();
        idle();
        #1;
        testsRun++; if (bpIf.pred_hist !== 8'h00) begin testsFailed++; $display("[TB] FAIL hist_still_zero got %h want 00", bpIf.pred_hist); end
        testsRun++; if (bpIf.pred_taken !== 1'b0 || bpIf.pred_target !== 32'h284) begin testsFailed++; $display("[TB] FAIL hist_ignored got %0b/%h want 0/284", bpIf.pred_taken, bpIf.pred_target); end
    endtask
`endif

    initial begin
        test_reset();
        test_mispredict();
        test_counter();
        test_target();
        test_aliasing();
        test_history();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
